// File: rtl/trail_map_if.sv
// Move-request / response channel of the trail map.
// The master issues move requests and receives crash results; the slave is the trail map.
interface trail_map_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_player;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic       resp_valid;
   logic       resp_crash;
   logic       resp_player;

   modport master (
      output req_valid, req_player, req_x, req_y,
      input  req_ready, resp_valid, resp_crash, resp_player
   );

   modport slave (
      input  req_valid, req_player, req_x, req_y,
      output req_ready, resp_valid, resp_crash, resp_player
   );
endinterface

// File: rtl/trail_map.sv
// Trail map: 160x120 occupancy board for a two-player light-cycle game.
// Wipes the board (drawing the border) after reset or on request, then
// serialises move requests, reporting a crash when a cell is already
// claimed or off the board, and plotting each newly claimed cell.
module trail_map #(
   parameter logic [2:0] P1_COLOUR     = 3'b101,
   parameter logic [2:0] P2_COLOUR     = 3'b011,
   parameter logic [2:0] BORDER_COLOUR = 3'b111
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        clear_req,
   trail_map_if.slave  bus,
   output logic        busy,
   output logic        plot,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour
);

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_READ  = 3'd2,
      S_CHECK = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   // Linear cell address y*160 + x, built from shifted copies of y.
   function automatic logic [14:0] cell_addr(input logic [7:0] cx, input logic [6:0] cy);
      return {1'b0, cy, 7'b0000000} + {3'b000, cy, 5'b00000} + {7'b0000000, cx};
   endfunction

   // Outer ring of the board.
   function automatic logic is_border(input logic [7:0] cx, input logic [6:0] cy);
      return (cx == 8'd0) || (cx == 8'd159) || (cy == 7'd0) || (cy == 7'd119);
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  cx_r;
   logic [6:0]  cy_r;
   logic        pend_r;
   logic        cap_player_r;
   logic [7:0]  cap_x_r;
   logic [6:0]  cap_y_r;
   logic        crash_r;
   logic        rd_bit_r;
   logic        plot_r;
   logic [7:0]  x_r;
   logic [6:0]  y_r;
   logic [2:0]  colour_r;
   logic        resp_valid_r;
   logic        resp_crash_r;
   logic        resp_player_r;
   logic        mem_r [0:19199];

   logic        ready_s;
   logic        accept_s;
   logic        in_range_s;
   logic        sweep_last_s;
   logic [14:0] sweep_addr_s;
   logic [14:0] req_addr_s;
   logic [14:0] cap_addr_s;

   assign ready_s      = (state_r == S_IDLE) && !clear_req && !pend_r;
   assign accept_s     = bus.req_valid && ready_s;
   assign in_range_s   = (bus.req_x < 8'd160) && (bus.req_y < 7'd120);
   assign sweep_last_s = (cx_r == 8'd159) && (cy_r == 7'd119);
   assign sweep_addr_s = cell_addr(cx_r, cy_r);
   assign req_addr_s   = cell_addr(bus.req_x, bus.req_y);
   assign cap_addr_s   = cell_addr(cap_x_r, cap_y_r);

   assign bus.req_ready   = ready_s;
   assign bus.resp_valid  = resp_valid_r;
   assign bus.resp_crash  = resp_crash_r;
   assign bus.resp_player = resp_player_r;
   assign busy            = (state_r != S_IDLE);
   assign plot            = plot_r;
   assign x               = x_r;
   assign y               = y_r;
   assign colour          = colour_r;

   // Next-state logic; a clear (new or pending) outranks a move request in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_CLEAR: if (sweep_last_s) state_s = S_IDLE; else state_s = S_CLEAR;
         S_IDLE: begin
            if (clear_req || pend_r) begin
               state_s = S_CLEAR;
            end else if (accept_s) begin
               if (in_range_s) state_s = S_READ; else state_s = S_RESP;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_READ:  state_s = S_CHECK;
         S_CHECK: state_s = S_RESP;
         S_RESP:  state_s = S_IDLE;
         default: state_s = S_CLEAR;
      endcase
   end

   // State register and pending-clear flag; the flag drops when the sweep starts.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_CLEAR;
         pend_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         if ((state_r != S_CLEAR) && (state_s == S_CLEAR)) pend_r <= 1'b0;
         else if (clear_req && (state_r != S_CLEAR))      pend_r <= 1'b1;
      end
   end

   // Sweep counter, x fastest; wraps to (0,0) so the next clear starts at the origin.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cx_r <= 8'd0;
         cy_r <= 7'd0;
      end else if (state_r == S_CLEAR) begin
         if (sweep_last_s) begin
            cx_r <= 8'd0;
            cy_r <= 7'd0;
         end else if (cx_r == 8'd159) begin
            cx_r <= 8'd0;
            cy_r <= cy_r + 7'd1;
         end else begin
            cx_r <= cx_r + 8'd1;
         end
      end
   end

   // Request capture and crash decision; the read is launched at acceptance so
   // its registered data is ready in READ and the plot strobe lands in CHECK.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cap_player_r <= 1'b0;
         cap_x_r      <= 8'd0;
         cap_y_r      <= 7'd0;
         crash_r      <= 1'b0;
      end else if (accept_s) begin
         cap_player_r <= bus.req_player;
         cap_x_r      <= bus.req_x;
         cap_y_r      <= bus.req_y;
      end else if (state_r == S_READ) begin
         crash_r      <= rd_bit_r;
      end
   end

   // Registered pixel and response outputs; plot and resp_valid are single-cycle strobes.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         plot_r        <= 1'b0;
         x_r           <= 8'd0;
         y_r           <= 7'd0;
         colour_r      <= 3'b000;
         resp_valid_r  <= 1'b0;
         resp_crash_r  <= 1'b0;
         resp_player_r <= 1'b0;
      end else begin
         plot_r       <= 1'b0;
         resp_valid_r <= 1'b0;
         case (state_r)
            S_CLEAR: begin
               plot_r   <= 1'b1;
               x_r      <= cx_r;
               y_r      <= cy_r;
               colour_r <= is_border(cx_r, cy_r) ? BORDER_COLOUR : 3'b000;
            end
            S_IDLE: begin
               if (accept_s && !in_range_s) begin
                  resp_valid_r  <= 1'b1;
                  resp_crash_r  <= 1'b1;
                  resp_player_r <= bus.req_player;
               end
            end
            S_READ: begin
               if (!rd_bit_r) begin
                  plot_r   <= 1'b1;
                  x_r      <= cap_x_r;
                  y_r      <= cap_y_r;
                  colour_r <= cap_player_r ? P2_COLOUR : P1_COLOUR;
               end
            end
            S_CHECK: begin
               resp_valid_r  <= 1'b1;
               resp_crash_r  <= crash_r;
               resp_player_r <= cap_player_r;
            end
            default: begin
            end
         endcase
      end
   end

   // Occupancy RAM: sweep writes, claim write at the end of CHECK, synchronous read.
   always_ff @(posedge CLOCK_50) begin
      if (state_r == S_CLEAR) begin
         mem_r[sweep_addr_s] <= is_border(cx_r, cy_r);
      end else if ((state_r == S_CHECK) && !crash_r) begin
         mem_r[cap_addr_s] <= 1'b1;
      end
      if (accept_s && in_range_s) begin
         rd_bit_r <= mem_r[req_addr_s];
      end
   end

endmodule

// File: tb/tb_trail_map.sv
// Self-checking bench for trail_map: reset state, full clear sweeps, directed
// and random move requests against an occupancy-grid reference model.
module tb_trail_map;

   logic       CLOCK_50;
   logic       resetn;
   logic       clear_req;
   logic       busy;
   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   trail_map_if bus ();

   trail_map dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .clear_req (clear_req),
      .bus       (bus),
      .busy      (busy),
      .plot      (plot),
      .x         (x),
      .y         (y),
      .colour    (colour)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int vectors    = 0;
   int miscompares = 0;
   bit occ [0:159][0:119];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit border_cell(input int cx, input int cy);
      return (cx == 0) || (cx == 159) || (cy == 0) || (cy == 119);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++)
            occ[i][j] = border_cell(i, j);
   endtask

   // Watches one full sweep from the current cycle until req_ready rises.
   task automatic sweep_check(input string tag);
      int n = 0, nb = 0, nz = 0, bad = 0, cyc = 0, expb = 0;
      bit early = 0;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++)
            if (border_cell(i, j)) expb++;
      do begin
         @(negedge CLOCK_50);
         cyc++;
         if (plot) begin
            if ((int'(x) != n % 160) || (int'(y) != n / 160)) bad++;
            if (border_cell(n % 160, n / 160)) begin
               if (colour == 3'b111) nb++; else bad++;
            end else begin
               if (colour == 3'b000) nz++; else bad++;
            end
            n++;
         end
         if (bus.resp_valid) bad++;
         if (bus.req_ready && (n < 19200)) early = 1'b1;
      end while (!bus.req_ready && (cyc < 19300));
      check({tag, "_ready"},   bus.req_ready, 1);
      check({tag, "_pulses"},  n, 19200);
      check({tag, "_border"},  nb, expb);
      check({tag, "_blank"},   nz, 19200 - expb);
      check({tag, "_order"},   bad, 0);
      check({tag, "_early"},   early, 0);
      @(negedge CLOCK_50);
      check({tag, "_noplot"},  plot, 0);
      model_clear();
   endtask

   // One move request, checked cycle by cycle against the occupancy model.
   task automatic do_req(input bit p, input int rx, input int ry, input bit clr_read);
      int  waitc = 0;
      bit  oor, crash;
      logic [31:0] col;
      @(negedge CLOCK_50);
      while (!bus.req_ready && (waitc < 50)) begin
         @(negedge CLOCK_50);
         waitc++;
      end
      check("ready_wait", bus.req_ready, 1);
      if (!bus.req_ready) return;
      bus.req_valid  = 1'b1;
      bus.req_player = p;
      bus.req_x      = 8'(rx);
      bus.req_y      = 7'(ry);
      oor   = (rx >= 160) || (ry >= 120);
      crash = oor ? 1'b1 : occ[rx][ry];
      if (!crash) occ[rx][ry] = 1'b1;
      col   = p ? 32'd3 : 32'd5;
      @(negedge CLOCK_50);
      bus.req_valid = 1'b0;
      check("busy_n1", busy, 1);
      if (oor) begin
         check("oor_valid",  bus.resp_valid, 1);
         check("oor_crash",  bus.resp_crash, 1);
         check("oor_player", bus.resp_player, p);
         check("oor_plot",   plot, 0);
      end else begin
         check("n1_valid", bus.resp_valid, 0);
         check("n1_plot",  plot, 0);
         if (clr_read) clear_req = 1'b1;
         @(negedge CLOCK_50);
         clear_req = 1'b0;
         check("n2_plot",  plot, !crash);
         check("n2_valid", bus.resp_valid, 0);
         if (!crash) begin
            check("n2_x",      x, rx);
            check("n2_y",      y, ry);
            check("n2_colour", colour, col);
         end
         @(negedge CLOCK_50);
         check("n3_valid",  bus.resp_valid, 1);
         check("n3_crash",  bus.resp_crash, crash);
         check("n3_player", bus.resp_player, p);
         check("n3_plot",   plot, 0);
      end
      @(negedge CLOCK_50);
      check("resp_pulse", bus.resp_valid, 0);
      check("hold_crash", bus.resp_crash, crash);
      check("hold_player", bus.resp_player, p);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_plot"},   plot, 0);
      check({tag, "_x"},      x, 0);
      check({tag, "_y"},      y, 0);
      check({tag, "_colour"}, colour, 0);
      check({tag, "_rv"},     bus.resp_valid, 0);
      check({tag, "_rc"},     bus.resp_crash, 0);
      check({tag, "_rp"},     bus.resp_player, 0);
      check({tag, "_ready"},  bus.req_ready, 0);
      check({tag, "_busy"},   busy, 1);
   endtask

   initial begin
      int seen;
      resetn         = 1'b0;
      clear_req      = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_player = 1'b0;
      bus.req_x      = 8'd0;
      bus.req_y      = 7'd0;
      model_clear();

      // Reset state
      repeat (3) @(negedge CLOCK_50);
      check_zero_outputs("rst");
      resetn = 1'b1;
      sweep_check("sweep0");

      // Directed moves
      do_req(1'b0, 5, 5, 1'b0);
      do_req(1'b1, 5, 5, 1'b0);
      do_req(1'b0, 0, 60, 1'b0);
      do_req(1'b1, 160, 10, 1'b0);
      do_req(1'b1, 159, 119, 1'b0);
      do_req(1'b0, 10, 120, 1'b0);

      // Random moves on a small patch so repeats collide
      for (int k = 0; k < 40; k++) begin
         int rx, ry;
         rx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 8));
         ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 8));
         do_req(1'($urandom_range(0, 1)), rx, ry, 1'b0);
      end

      // Clear in IDLE beats a simultaneous move request
      @(negedge CLOCK_50);
      clear_req      = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_player = 1'b0;
      bus.req_x      = 8'd7;
      bus.req_y      = 7'd7;
      #1;
      check("clr_prio_ready", bus.req_ready, 0);
      @(negedge CLOCK_50);
      clear_req     = 1'b0;
      bus.req_valid = 1'b0;
      check("clr_prio_busy", busy, 1);
      sweep_check("sweep1");
      do_req(1'b0, 5, 5, 1'b0);

      // Clear during READ: response completes, then a full sweep
      do_req(1'b1, 6, 6, 1'b1);
      sweep_check("sweep2");
      do_req(1'b0, 5, 5, 1'b0);

      // Reset during CHECK aborts the transaction
      seen = 0;
      @(negedge CLOCK_50);
      bus.req_valid  = 1'b1;
      bus.req_player = 1'b1;
      bus.req_x      = 8'd150;
      bus.req_y      = 7'd100;
      check("ab_ready", bus.req_ready, 1);
      @(negedge CLOCK_50);
      bus.req_valid = 1'b0;
      @(negedge CLOCK_50);
      check("ab_plot_check", plot, 1);
      resetn = 1'b0;
      #1;
      check_zero_outputs("ab");
      repeat (3) begin
         @(negedge CLOCK_50);
         if (bus.resp_valid) seen++;
      end
      check("ab_no_resp", seen, 0);
      resetn = 1'b1;
      sweep_check("sweep3");
      do_req(1'b1, 150, 100, 1'b0);
      do_req(1'b0, 150, 100, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
